ticker_bist_ctrl: RTL

- Built-in self-test sequencer for the RGB ticker block.
- Runs the ticker twice from reset, first with fault injection off (golden run) and then with it on (faulty run).
- Compresses the ticker's RGB output in each run into a MISR signature and flags a detected fault when the two signatures differ.
- Sits beside the ticker: it drives the ticker's reset and fault inputs and observes its RGB output.

---
 rtl/ticker_bist_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ticker_bist_ctrl.sv
// Self-test sequencer for the RGB ticker: a golden run, then a fault-injected run,
// each compressed into a MISR signature; the two signatures are compared at the end.
module ticker_bist_ctrl #(
  parameter int                RUN_CYCLES    = 64,
  parameter int                SETTLE_CYCLES = 4,
  parameter int                SIG_W         = 8,
  parameter logic [SIG_W-1:0]  POLY          = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ticker_rgb,
  output logic             ticker_rst,
  output logic             fault_en,
  output logic             busy,
  output logic             done,
  output logic             detected,
  output logic [SIG_W-1:0] golden_sig,
  output logic [SIG_W-1:0] faulty_sig
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // RST_G | ticker held in reset, fault off
  // RUN_G | golden run, MISR into golden_sig
  // RST_F | ticker held in reset, fault on
  // RUN_F | faulty run, MISR into faulty_sig
  // CMP   | compare signatures
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE, RST_G, RUN_G, RST_F, RUN_F, CMP, DONE
  } state_t;

  localparam int MAXC = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] RUN_LD    = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_ld;
  logic            cnt_zero;
  logic            tr_nxt, fe_nxt, busy_nxt, done_nxt;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [2:0]       d);
    logic [SIG_W-1:0] r;
    r = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) r = r ^ POLY;
    r = r ^ SIG_W'(d);
    return r;
  endfunction

  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RST_G;
      RST_G:   if (cnt_zero) state_nxt = RUN_G;
      RUN_G:   if (cnt_zero) state_nxt = RST_F;
      RST_F:   if (cnt_zero) state_nxt = RUN_F;
      RUN_F:   if (cnt_zero) state_nxt = CMP;
      CMP:                   state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Counter load value and registered outputs both follow the state being entered.
  always_comb begin
    cnt_ld   = '0;
    tr_nxt   = 1'b0;
    fe_nxt   = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      RST_G: begin cnt_ld = SETTLE_LD; tr_nxt = 1'b1; busy_nxt = 1'b1; end
      RUN_G: begin cnt_ld = RUN_LD;    busy_nxt = 1'b1; end
      RST_F: begin cnt_ld = SETTLE_LD; tr_nxt = 1'b1; fe_nxt = 1'b1; busy_nxt = 1'b1; end
      RUN_F: begin cnt_ld = RUN_LD;    fe_nxt = 1'b1; busy_nxt = 1'b1; end
      CMP:   begin fe_nxt = 1'b1; busy_nxt = 1'b1; end
      DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ticker_rst <= 1'b1;
      fault_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ticker_rst <= tr_nxt;
      fault_en   <= fe_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      if (state_nxt != state) cnt <= cnt_ld;
      else if (!cnt_zero)     cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      detected   <= 1'b0;
      golden_sig <= '0;
      faulty_sig <= '0;
    end else begin
      if (state == IDLE && start) begin
        detected   <= 1'b0;
        golden_sig <= '0;
        faulty_sig <= '0;
      end
      if (state == RUN_G) golden_sig <= misr_step(golden_sig, ticker_rgb);
      if (state == RUN_F) faulty_sig <= misr_step(faulty_sig, ticker_rgb);
      if (state == CMP)   detected   <= (golden_sig != faulty_sig);
    end
  end

endmodule
